// File: rtl/exu_wbck_sched_pkg.sv
// Shared write-back constants and types for the integer register file write port.
// Also holds a helper that sizes the starvation counter.
package exu_wbck_sched_pkg;

    localparam int E203_XLEN            = 32;
    localparam int E203_RFIDX_W         = 5;
    localparam int E203_RFREG_NUM       = 32;
    localparam int E203_WBCK_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_LNG  = 2'd2
    } wbck_gnt_e;

    // Counter must be able to hold the value max_cnt itself.
    function automatic int starve_cnt_w(input int max_cnt);
        return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
    endfunction

endpackage

// File: rtl/exu_wbck_scoreboard.sv
// Pending-write scoreboard for outstanding long-pipe results, plus the issue-side
// RAW/WAW hazard check against both the scoreboard and the registered output stage.
module exu_wbck_scoreboard
    import exu_wbck_sched_pkg::*;
#(
    parameter int RFIDX_W   = E203_RFIDX_W,
    parameter int RFREG_NUM = E203_RFREG_NUM
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sb_set_valid,
    output logic               sb_set_ready,
    input  logic [RFIDX_W-1:0] sb_set_idx,
    input  logic               clr_valid,
    input  logic [RFIDX_W-1:0] clr_idx,
    input  logic [RFIDX_W-1:0] chk_src1_idx,
    input  logic [RFIDX_W-1:0] chk_src2_idx,
    input  logic [RFIDX_W-1:0] chk_dest_idx,
    input  logic               ostg_wen,
    input  logic [RFIDX_W-1:0] ostg_idx,
    input  logic [RFIDX_W-1:0] probe_idx,
    output logic               probe_pending,
    output logic               dep_hazard
);

    logic [RFREG_NUM-1:0] pending;
    logic [RFREG_NUM-1:0] pending_nxt;
    logic [RFREG_NUM-1:0] set_mask;
    logic [RFREG_NUM-1:0] clr_mask;
    logic                 pending_ld;
    logic                 src1_hit;
    logic                 src2_hit;
    logic                 dest_hit;

    // A set is only accepted while the bit is clear, so it can never collide with a clear.
    assign sb_set_ready = !pending[sb_set_idx];

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (sb_set_valid && sb_set_ready && (sb_set_idx != '0)) begin
            set_mask[sb_set_idx] = 1'b1;
        end
        if (clr_valid) begin
            clr_mask[clr_idx] = 1'b1;
        end
    end

    assign pending_nxt = (pending | set_mask) & ~clr_mask & {{(RFREG_NUM-1){1'b1}}, 1'b0};
    assign pending_ld  = |(set_mask | clr_mask);

    sirv_gnrl_dfflr_sync #(.DW(RFREG_NUM)) u_pending_dff (
        .clk   (clk),
        .rst_n (rst_n),
        .lden  (pending_ld),
        .dnxt  (pending_nxt),
        .qout  (pending)
    );

    // Sources also see the output stage because the register file has no bypass.
    assign src1_hit = (chk_src1_idx != '0)
                   && (pending[chk_src1_idx] || (ostg_wen && (ostg_idx == chk_src1_idx)));
    assign src2_hit = (chk_src2_idx != '0)
                   && (pending[chk_src2_idx] || (ostg_wen && (ostg_idx == chk_src2_idx)));
    assign dest_hit = (chk_dest_idx != '0) && pending[chk_dest_idx];

    assign dep_hazard    = src1_hit | src2_hit | dest_hit;
    assign probe_pending = pending[probe_idx];

endmodule

// File: rtl/sirv_gnrl_dffs.sv
// General-purpose D flip-flop with load enable and synchronous active-low reset to zero.
module sirv_gnrl_dfflr_sync #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            qout <= '0;
        end else if (lden) begin
            qout <= dnxt;
        end
    end

endmodule

// File: rtl/exu_wbck_sched.sv
// Write-back scheduler: arbitrates ALU and long-pipe results onto the single
// register file write port through a one-cycle registered output stage.
module exu_wbck_sched
    import exu_wbck_sched_pkg::*;
#(
    parameter int XLEN       = E203_XLEN,
    parameter int RFIDX_W    = E203_RFIDX_W,
    parameter int RFREG_NUM  = E203_RFREG_NUM,
    parameter int STARVE_MAX = E203_WBCK_STARVE_MAX
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alu_wbck_valid,
    output logic               alu_wbck_ready,
    input  logic [RFIDX_W-1:0] alu_wbck_idx,
    input  logic [XLEN-1:0]    alu_wbck_dat,
    input  logic               lng_wbck_valid,
    output logic               lng_wbck_ready,
    input  logic [RFIDX_W-1:0] lng_wbck_idx,
    input  logic [XLEN-1:0]    lng_wbck_dat,
    input  logic               sb_set_valid,
    output logic               sb_set_ready,
    input  logic [RFIDX_W-1:0] sb_set_idx,
    input  logic [RFIDX_W-1:0] chk_src1_idx,
    input  logic [RFIDX_W-1:0] chk_src2_idx,
    input  logic [RFIDX_W-1:0] chk_dest_idx,
    output logic               dep_hazard,
    output logic               wbck_dest_wen,
    output logic [RFIDX_W-1:0] wbck_dest_idx,
    output logic [XLEN-1:0]    wbck_dest_dat
);

    localparam int CNT_W = starve_cnt_w(STARVE_MAX);

    wbck_gnt_e          gnt;
    logic [CNT_W-1:0]   starve_cnt;
    logic [CNT_W-1:0]   starve_nxt;
    logic               starved;
    logic               grant;
    logic [RFIDX_W-1:0] sel_idx;
    logic [XLEN-1:0]    sel_dat;
    logic               wen_nxt;
    logic               alu_dest_pending;

    assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

    // ALU has priority unless the long pipe has lost STARVE_MAX times in a row.
    always_comb begin
        gnt = GNT_NONE;
        if (lng_wbck_valid && (starved || !alu_wbck_valid)) begin
            gnt = GNT_LNG;
        end else if (alu_wbck_valid) begin
            gnt = GNT_ALU;
        end
    end

    assign alu_wbck_ready = rst_n && (gnt == GNT_ALU);
    assign lng_wbck_ready = rst_n && (gnt == GNT_LNG);

    always_comb begin
        starve_nxt = '0;
        if (lng_wbck_valid && !lng_wbck_ready) begin
            starve_nxt = starved ? starve_cnt : starve_cnt + CNT_W'(1);
        end
    end

    sirv_gnrl_dfflr_sync #(.DW(CNT_W)) u_starve_dff (
        .clk   (clk),
        .rst_n (rst_n),
        .lden  (1'b1),
        .dnxt  (starve_nxt),
        .qout  (starve_cnt)
    );

    // ---- output stage: grant registered onto the register file port ----
    assign grant   = alu_wbck_ready | lng_wbck_ready;
    assign sel_idx = lng_wbck_ready ? lng_wbck_idx : alu_wbck_idx;
    assign sel_dat = lng_wbck_ready ? lng_wbck_dat : alu_wbck_dat;
    assign wen_nxt = grant && (sel_idx != '0);

    sirv_gnrl_dfflr_sync #(.DW(1)) u_wen_dff (
        .clk   (clk),
        .rst_n (rst_n),
        .lden  (1'b1),
        .dnxt  (wen_nxt),
        .qout  (wbck_dest_wen)
    );

    sirv_gnrl_dfflr_sync #(.DW(RFIDX_W)) u_idx_dff (
        .clk   (clk),
        .rst_n (rst_n),
        .lden  (grant),
        .dnxt  (sel_idx),
        .qout  (wbck_dest_idx)
    );

    sirv_gnrl_dfflr_sync #(.DW(XLEN)) u_dat_dff (
        .clk   (clk),
        .rst_n (rst_n),
        .lden  (grant),
        .dnxt  (sel_dat),
        .qout  (wbck_dest_dat)
    );

    exu_wbck_scoreboard #(
        .RFIDX_W   (RFIDX_W),
        .RFREG_NUM (RFREG_NUM)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .sb_set_valid  (sb_set_valid),
        .sb_set_ready  (sb_set_ready),
        .sb_set_idx    (sb_set_idx),
        .clr_valid     (lng_wbck_valid && lng_wbck_ready),
        .clr_idx       (lng_wbck_idx),
        .chk_src1_idx  (chk_src1_idx),
        .chk_src2_idx  (chk_src2_idx),
        .chk_dest_idx  (chk_dest_idx),
        .ostg_wen      (wbck_dest_wen),
        .ostg_idx      (wbck_dest_idx),
        .probe_idx     (alu_wbck_idx),
        .probe_pending (alu_dest_pending),
        .dep_hazard    (dep_hazard)
    );

    // Issue must never let an ALU op write a register with a long-pipe write outstanding.
    alu_wr_pending_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(alu_wbck_valid && alu_wbck_ready && alu_dest_pending));

endmodule

// File: tb/tb_exu_wbck_sched.sv
// Bench for exu_wbck_sched: fixed vector table, hand-written starvation and reset
// sequences, then randomized traffic against a behavioural model.
module tb_exu_wbck_sched;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_wbck_valid;
    logic        alu_wbck_ready;
    logic [4:0]  alu_wbck_idx;
    logic [31:0] alu_wbck_dat;
    logic        lng_wbck_valid;
    logic        lng_wbck_ready;
    logic [4:0]  lng_wbck_idx;
    logic [31:0] lng_wbck_dat;
    logic        sb_set_valid;
    logic        sb_set_ready;
    logic [4:0]  sb_set_idx;
    logic [4:0]  chk_src1_idx;
    logic [4:0]  chk_src2_idx;
    logic [4:0]  chk_dest_idx;
    logic        dep_hazard;
    logic        wbck_dest_wen;
    logic [4:0]  wbck_dest_idx;
    logic [31:0] wbck_dest_dat;

    always #5 clk = ~clk;

    exu_wbck_sched #(
        .XLEN(32), .RFIDX_W(5), .RFREG_NUM(32), .STARVE_MAX(SMAX)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_wbck_valid (alu_wbck_valid),
        .alu_wbck_ready (alu_wbck_ready),
        .alu_wbck_idx   (alu_wbck_idx),
        .alu_wbck_dat   (alu_wbck_dat),
        .lng_wbck_valid (lng_wbck_valid),
        .lng_wbck_ready (lng_wbck_ready),
        .lng_wbck_idx   (lng_wbck_idx),
        .lng_wbck_dat   (lng_wbck_dat),
        .sb_set_valid   (sb_set_valid),
        .sb_set_ready   (sb_set_ready),
        .sb_set_idx     (sb_set_idx),
        .chk_src1_idx   (chk_src1_idx),
        .chk_src2_idx   (chk_src2_idx),
        .chk_dest_idx   (chk_dest_idx),
        .dep_hazard     (dep_hazard),
        .wbck_dest_wen  (wbck_dest_wen),
        .wbck_dest_idx  (wbck_dest_idx),
        .wbck_dest_dat  (wbck_dest_dat)
    );

    typedef struct {
        logic        av; logic [4:0] ai; logic [31:0] ad;
        logic        lv; logic [4:0] li; logic [31:0] ld;
        logic        sv; logic [4:0] si;
        logic [4:0]  s1; logic [4:0] s2; logic [4:0] sd;
        logic        e_ar; logic e_lr; logic e_sr; logic e_hz;
        logic        e_wen; logic [4:0] e_idx; logic [31:0] e_dat;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    vec_t tbl[19];

    // behavioural model state
    bit          pend[32];
    int          starve;
    logic        m_wen;
    logic [4:0]  m_idx;
    logic [31:0] m_dat;
    logic        e_aw, e_lw, e_sr, e_hz;
    int          cand[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic av, input logic [4:0] ai, input logic [31:0] ad,
                                input logic lv, input logic [4:0] li, input logic [31:0] ld,
                                input logic sv, input logic [4:0] si,
                                input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] sd,
                                input logic ar, input logic lr, input logic sr, input logic hz,
                                input logic wen, input logic [4:0] idx, input logic [31:0] dat);
        vec_t v;
        v.av = av; v.ai = ai; v.ad = ad; v.lv = lv; v.li = li; v.ld = ld;
        v.sv = sv; v.si = si; v.s1 = s1; v.s2 = s2; v.sd = sd;
        v.e_ar = ar; v.e_lr = lr; v.e_sr = sr; v.e_hz = hz;
        v.e_wen = wen; v.e_idx = idx; v.e_dat = dat;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        alu_wbck_valid = v.av; alu_wbck_idx = v.ai; alu_wbck_dat = v.ad;
        lng_wbck_valid = v.lv; lng_wbck_idx = v.li; lng_wbck_dat = v.ld;
        sb_set_valid   = v.sv; sb_set_idx   = v.si;
        chk_src1_idx   = v.s1; chk_src2_idx = v.s2; chk_dest_idx = v.sd;
    endtask

    function automatic logic src_hz(input logic [4:0] i);
        return (i != 0) && (pend[i] || (m_wen && m_idx == i));
    endfunction

    initial begin
        // idle / ALU / scoreboard / idx 0 / set+clear cases, applied from reset state
        tbl[0]  = mk(0,0,0,           0,0,0,            0,0, 0,0,0, 0,0,1,0, 0,0,32'h0);
        tbl[1]  = mk(1,5,32'hDEADBEEF,0,0,0,            0,0, 0,0,0, 1,0,1,0, 1,5,32'hDEADBEEF);
        tbl[2]  = mk(0,0,0,           0,0,0,            0,0, 5,0,0, 0,0,1,1, 0,5,32'hDEADBEEF);
        tbl[3]  = mk(0,0,0,           0,0,0,            1,7, 0,0,0, 0,0,1,0, 0,5,32'hDEADBEEF);
        tbl[4]  = mk(0,0,0,           0,0,0,            1,7, 7,0,0, 0,0,0,1, 0,5,32'hDEADBEEF);
        tbl[5]  = mk(0,0,0,           0,0,0,            0,0, 0,0,7, 0,0,1,1, 0,5,32'hDEADBEEF);
        tbl[6]  = mk(0,0,0,           1,7,32'h12345678, 0,0, 0,7,0, 0,1,1,1, 1,7,32'h12345678);
        tbl[7]  = mk(0,0,0,           0,0,0,            0,0, 0,7,0, 0,0,1,1, 0,7,32'h12345678);
        tbl[8]  = mk(0,0,0,           0,0,0,            0,0, 0,7,7, 0,0,1,0, 0,7,32'h12345678);
        tbl[9]  = mk(1,0,32'hFFFFFFFF,0,0,0,            0,0, 0,0,0, 1,0,1,0, 0,0,32'hFFFFFFFF);
        tbl[10] = mk(0,0,0,           0,0,0,            1,0, 0,0,0, 0,0,1,0, 0,0,32'hFFFFFFFF);
        tbl[11] = mk(1,3,32'h11,      1,9,32'h22,       0,0, 0,0,0, 1,0,1,0, 1,3,32'h11);
        tbl[12] = mk(0,0,0,           0,0,0,            0,0, 0,0,0, 0,0,1,0, 0,3,32'h11);
        tbl[13] = mk(0,0,0,           0,0,0,            1,4, 0,0,0, 0,0,1,0, 0,3,32'h11);
        tbl[14] = mk(0,0,0,           1,4,32'hA5,       1,6, 4,6,0, 0,1,1,1, 1,4,32'hA5);
        tbl[15] = mk(0,0,0,           0,0,0,            0,0, 0,0,6, 0,0,1,1, 0,4,32'hA5);
        tbl[16] = mk(0,0,0,           0,0,0,            0,0, 4,0,0, 0,0,1,0, 0,4,32'hA5);
        tbl[17] = mk(0,0,0,           1,6,32'h66,       0,0, 0,0,6, 0,1,1,1, 1,6,32'h66);
        tbl[18] = mk(0,0,0,           0,0,0,            0,0, 0,0,6, 0,0,1,0, 0,6,32'h66);

        drive(tbl[0]);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("reset wen", wbck_dest_wen, 1'b0);
        chk("reset idx", wbck_dest_idx, 5'd0);
        chk("reset dat", wbck_dest_dat, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i]);
            #3;
            chk($sformatf("t%0d alu_ready", i), alu_wbck_ready, tbl[i].e_ar);
            chk($sformatf("t%0d lng_ready", i), lng_wbck_ready, tbl[i].e_lr);
            chk($sformatf("t%0d sb_set_ready", i), sb_set_ready, tbl[i].e_sr);
            chk($sformatf("t%0d dep_hazard", i), dep_hazard, tbl[i].e_hz);
            @(posedge clk); #1;
            chk($sformatf("t%0d wen", i), wbck_dest_wen, tbl[i].e_wen);
            chk($sformatf("t%0d idx", i), wbck_dest_idx, tbl[i].e_idx);
            chk($sformatf("t%0d dat", i), wbck_dest_dat, tbl[i].e_dat);
        end

        // both sources valid continuously: ALU x4, long pipe on the 5th, then ALU again
        for (int k = 1; k <= 7; k++) begin
            drive(mk(1,1,32'hA1, 1,2,32'hBB, 0,0, 0,0,0, 0,0,0,0, 0,0,0));
            #3;
            chk($sformatf("starve%0d alu_ready", k), alu_wbck_ready, (k != 5));
            chk($sformatf("starve%0d lng_ready", k), lng_wbck_ready, (k == 5));
            @(posedge clk); #1;
            chk($sformatf("starve%0d wen", k), wbck_dest_wen, 1'b1);
            chk($sformatf("starve%0d idx", k), wbck_dest_idx, (k == 5) ? 5'd2 : 5'd1);
            chk($sformatf("starve%0d dat", k), wbck_dest_dat, (k == 5) ? 32'hBB : 32'hA1);
        end

        // reset with a pending bit, a held long pipe and a full output stage
        drive(mk(1,8,32'h88, 0,0,0, 1,3, 0,0,0, 0,0,0,0, 0,0,0));
        #3;
        @(posedge clk); #1;
        chk("rstseq pre wen", wbck_dest_wen, 1'b1);
        chk("rstseq pre idx", wbck_dest_idx, 5'd8);
        drive(mk(1,8,32'h99, 1,9,32'h77, 0,0, 3,0,0, 0,0,0,0, 0,0,0));
        rst_n = 1'b0;
        #3;
        chk("rstseq alu_ready in reset", alu_wbck_ready, 1'b0);
        chk("rstseq lng_ready in reset", lng_wbck_ready, 1'b0);
        @(posedge clk); #1;
        chk("rstseq wen", wbck_dest_wen, 1'b0);
        chk("rstseq idx", wbck_dest_idx, 5'd0);
        chk("rstseq dat", wbck_dest_dat, 32'h0);
        rst_n = 1'b1;
        drive(mk(0,0,0, 0,0,0, 0,0, 3,0,0, 0,0,0,0, 0,0,0));
        #3;
        chk("rstseq pending cleared", dep_hazard, 1'b0);
        chk("rstseq sb_set_ready", sb_set_ready, 1'b1);
        @(posedge clk); #1;
        chk("rstseq post wen", wbck_dest_wen, 1'b0);

        // randomized traffic against the model, starting from the clean post-reset state
        foreach (pend[r]) pend[r] = 1'b0;
        starve = 0; m_wen = 1'b0; m_idx = 5'd0; m_dat = 32'h0;
        alu_wbck_valid = 1'b0;
        lng_wbck_valid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!alu_wbck_valid && $urandom_range(0, 9) < 6) begin
                alu_wbck_idx = 5'($urandom_range(0, 31));
                if (pend[alu_wbck_idx]) alu_wbck_idx = 5'd0;
                alu_wbck_dat   = $urandom;
                alu_wbck_valid = 1'b1;
            end
            if (!lng_wbck_valid && $urandom_range(0, 1) == 1) begin
                cand.delete();
                for (int r = 1; r < 32; r++) if (pend[r]) cand.push_back(r);
                if (cand.size() > 0) begin
                    lng_wbck_idx   = 5'(cand[$urandom_range(0, cand.size() - 1)]);
                    lng_wbck_dat   = $urandom;
                    lng_wbck_valid = 1'b1;
                end
            end
            sb_set_valid = ($urandom_range(0, 9) < 4);
            sb_set_idx   = 5'($urandom_range(0, 31));
            if (alu_wbck_valid && sb_set_idx == alu_wbck_idx) sb_set_idx = 5'd0;
            chk_src1_idx = 5'($urandom_range(0, 31));
            chk_src2_idx = 5'($urandom_range(0, 31));
            chk_dest_idx = 5'($urandom_range(0, 31));

            e_lw = lng_wbck_valid && (starve == SMAX || !alu_wbck_valid);
            e_aw = alu_wbck_valid && !e_lw;
            e_sr = !pend[sb_set_idx];
            e_hz = src_hz(chk_src1_idx) || src_hz(chk_src2_idx)
                || (chk_dest_idx != 0 && pend[chk_dest_idx]);
            #3;
            chk($sformatf("rnd%0d alu_ready", c), alu_wbck_ready, e_aw);
            chk($sformatf("rnd%0d lng_ready", c), lng_wbck_ready, e_lw);
            chk($sformatf("rnd%0d sb_set_ready", c), sb_set_ready, e_sr);
            chk($sformatf("rnd%0d dep_hazard", c), dep_hazard, e_hz);
            @(posedge clk); #1;

            if (e_aw) begin
                m_wen = (alu_wbck_idx != 0); m_idx = alu_wbck_idx; m_dat = alu_wbck_dat;
            end else if (e_lw) begin
                m_wen = (lng_wbck_idx != 0); m_idx = lng_wbck_idx; m_dat = lng_wbck_dat;
            end else begin
                m_wen = 1'b0;
            end
            if (sb_set_valid && e_sr && sb_set_idx != 0) pend[sb_set_idx] = 1'b1;
            if (e_lw) pend[lng_wbck_idx] = 1'b0;
            if (lng_wbck_valid && !e_lw) starve = (starve < SMAX) ? starve + 1 : SMAX;
            else starve = 0;

            chk($sformatf("rnd%0d wen", c), wbck_dest_wen, m_wen);
            chk($sformatf("rnd%0d idx", c), wbck_dest_idx, m_idx);
            chk($sformatf("rnd%0d dat", c), wbck_dest_dat, m_dat);

            if (e_aw) alu_wbck_valid = 1'b0;
            if (e_lw) lng_wbck_valid = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exu_wbck_sched.md
Name: exu_wbck_sched

Overview:
Write-back scheduler for the integer register file's single write port. Arbitrates between the single-cycle ALU result and the long-pipe result (LSU / CGRA offload) using valid/ready handshakes. Keeps a per-register pending scoreboard so issue logic can stall on RAW/WAW hazards against outstanding long-pipe writes. Drives the register file write port from a registered output stage.

Parameters:
XLEN, 32, data width
RFIDX_W, 5, register index width
RFREG_NUM, 32, number of architectural registers
STARVE_MAX, 4, consecutive lost arbitrations after which the long pipe is forced to win

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
alu_wbck_valid  input  1  ALU result valid
alu_wbck_ready  output  1  ALU result accepted this cycle
alu_wbck_idx  input  RFIDX_W  ALU destination register
alu_wbck_dat  input  XLEN  ALU result data
lng_wbck_valid  input  1  long-pipe result valid
lng_wbck_ready  output  1  long-pipe result accepted this cycle
lng_wbck_idx  input  RFIDX_W  long-pipe destination register
lng_wbck_dat  input  XLEN  long-pipe result data
sb_set_valid  input  1  issue of a long-pipe op that writes sb_set_idx
sb_set_ready  output  1  scoreboard can accept the set
sb_set_idx  input  RFIDX_W  register to mark pending
chk_src1_idx  input  RFIDX_W  issue-stage source 1
chk_src2_idx  input  RFIDX_W  issue-stage source 2
chk_dest_idx  input  RFIDX_W  issue-stage destination
dep_hazard  output  1  a checked index is pending or in the output stage
wbck_dest_wen  output  1  register file write enable
wbck_dest_idx  output  RFIDX_W  register file write index
wbck_dest_dat  output  XLEN  register file write data

Behaviour:
- Reset (synchronous, rst_n low at a clk edge): wbck_dest_wen=0, wbck_dest_idx=0, wbck_dest_dat=0, scoreboard all clear, starve counter 0. Reset mid-transaction drops in-flight data. Pending bits are cleared, and the issue side must also flush.
- Arbitration is combinational on valids. At most one grant per cycle.
- Default priority is ALU over long pipe. If starve_cnt==STARVE_MAX, the long pipe wins over the ALU.
- starve_cnt increments when lng_wbck_valid is high and the long pipe is not granted. It saturates at STARVE_MAX and clears when the long pipe is granted or lng_wbck_valid is low.
- ready is high only for the granted source. The handshake is valid&ready. A source holds valid, idx and dat stable until ready.
- Output stage: one-cycle latency. On a grant, wbck_dest_idx/dat are registered next cycle. wbck_dest_wen=1 unless idx==0, where the write is consumed but wen=0. With no grant, wbck_dest_wen=0 and idx/dat hold their previous values.
- Scoreboard: a pending[RFREG_NUM] register vector. Bit 0 is never set.
  - sb_set_ready = !pending[sb_set_idx]. This blocks a second outstanding long write to the same register (WAW).
  - An accepted set of index 0 is a no-op.
  - A long-pipe handshake clears pending[lng_wbck_idx] at the next edge.
  - A set and a clear of the same index in the same cycle cannot occur, because set requires the bit clear. A set and a clear of different indices in the same cycle both apply.
- dep_hazard = pending[src1]|pending[src2]|pending[dest]. It is also high if the output stage holds wen=1 with idx equal to src1/src2, since there is no regfile bypass. Index 0 never causes a hazard.
- An ALU write to a register pending in the scoreboard is an issue-side protocol violation. Assert this in simulation only; RTL behaviour is unspecified.

Decomposition:
- Shared defines (existing E203-style include): XLEN, RFIDX_W, RFREG_NUM.
- Add a new shared constant WBCK_STARVE_MAX.
- One natural sub-module: exu_wbck_scoreboard (pending vector, set/clear, hazard compare).
- The arbiter and output stage stay in the top module.
- Use the existing general DFF cells with load enable, in their synchronous-reset variant.

Test Plan:
- Reset then idle -> wbck_dest_wen=0, dep_hazard=0 for all indices, both readies 0.
- ALU only: valid, idx=5, dat=0xDEADBEEF -> ready same cycle; next cycle wen=1, idx=5, dat=0xDEADBEEF; regfile x5 reads 0xDEADBEEF.
- ALU and long pipe both valid continuously (STARVE_MAX=4) -> ALU granted 4 cycles, long pipe granted on the 5th, counter clears, ALU wins again.
- Set idx=7, then check src1=7 -> dep_hazard=1, and a second set of 7 sees sb_set_ready=0. Long-pipe write of idx=7 -> pending clears next edge and dep_hazard=0 after the output stage drains.
- ALU write to idx=0 with dat=0xFFFFFFFF -> ready=1, wbck_dest_wen stays 0. Set idx=0 -> no hazard.
- Set idx=3, hold the long pipe valid, pull rst_n low for one edge -> pending cleared, wen=0, readies 0 while in reset.
